// File: rtl/display_scan_controller.sv
// Four-digit multiplexed seven-segment scan controller with per-frame input snapshot,
// dead-time anti-ghosting and digit blinking. Define LZ_BLANK_EN to blank a leading zero on digit 3.
module display_scan_controller #(
    parameter int REFRESH_DIV  = 100000,
    parameter int DEAD_CYCLES  = 4,
    parameter int BLINK_FRAMES = 100
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] digits,
    input  logic [3:0]  dp_mask,
    input  logic [3:0]  blink_mask,
    output logic [3:0]  num,
    output logic [3:0]  an,
    output logic        dp,
    output logic        frame_start
);

    localparam int DIV_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int FRM_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);
    localparam logic [DIV_W-1:0] DEAD_LIM = DIV_W'(DEAD_CYCLES);
    localparam logic [FRM_W-1:0] FRM_LAST = FRM_W'(BLINK_FRAMES - 1);

    logic [DIV_W-1:0] div_cnt_q,     div_cnt_d;
    logic [1:0]       digit_sel_q,   digit_sel_d;
    logic [FRM_W-1:0] frame_cnt_q,   frame_cnt_d;
    logic             blink_phase_q, blink_phase_d;
    logic [15:0]      digits_snap_q, digits_snap_d;
    logic [3:0]       dp_snap_q,     dp_snap_d;
    logic [3:0]       blink_snap_q,  blink_snap_d;
    logic [3:0]       num_q,         num_d;
    logic [3:0]       an_q,          an_d;
    logic             dp_q,          dp_d;
    logic             frame_start_q, frame_start_d;

    logic             div_wrap_s;
    logic             frame_end_s;
    logic [3:0]       slot_nibble_s;
    logic             slot_off_s;
    logic             lz_off_s;

    function automatic logic [3:0] pick_nibble(input logic [15:0] word, input logic [1:0] sel);
        logic [3:0] nib;
        case (sel)
            2'd0:    nib = word[3:0];
            2'd1:    nib = word[7:4];
            2'd2:    nib = word[11:8];
            2'd3:    nib = word[15:12];
            default: nib = 4'd0;
        endcase
        return nib;
    endfunction

    // Slot/digit counters, frame counter, blink phase and snapshot capture
    always_comb begin
        div_wrap_s    = (div_cnt_q == DIV_LAST);
        frame_end_s   = div_wrap_s && (digit_sel_q == 2'd3);
        digits_snap_d = digits_snap_q;
        dp_snap_d     = dp_snap_q;
        blink_snap_d  = blink_snap_q;
        frame_cnt_d   = frame_cnt_q;
        blink_phase_d = blink_phase_q;
        if (div_wrap_s) begin
            div_cnt_d   = {DIV_W{1'b0}};
            digit_sel_d = digit_sel_q + 2'd1;
        end else begin
            div_cnt_d   = div_cnt_q + DIV_W'(1);
            digit_sel_d = digit_sel_q;
        end
        if (frame_end_s) begin
            digits_snap_d = digits;
            dp_snap_d     = dp_mask;
            blink_snap_d  = blink_mask;
            if (frame_cnt_q == FRM_LAST) begin
                frame_cnt_d   = {FRM_W{1'b0}};
                blink_phase_d = ~blink_phase_q;
            end else begin
                frame_cnt_d   = frame_cnt_q + FRM_W'(1);
                blink_phase_d = blink_phase_q;
            end
        end else begin
            frame_cnt_d   = frame_cnt_q;
            blink_phase_d = blink_phase_q;
        end
    end

    // Output decode from the current slot state; num tracks the slot even in dead time
    always_comb begin
        slot_nibble_s = pick_nibble(digits_snap_q, digit_sel_q);
`ifdef LZ_BLANK_EN
        lz_off_s = (digit_sel_q == 2'd3) && (slot_nibble_s == 4'd0);
`else
        lz_off_s = 1'b0;
`endif
        slot_off_s = (div_cnt_q < DEAD_LIM)
                   || (blink_phase_q && blink_snap_q[digit_sel_q])
                   || lz_off_s;
        num_d         = slot_nibble_s;
        frame_start_d = frame_end_s;
        if (slot_off_s) begin
            an_d = 4'b1111;
            dp_d = 1'b1;
        end else begin
            an_d = ~(4'b0001 << digit_sel_q);
            dp_d = ~dp_snap_q[digit_sel_q];
        end
    end

    // State and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt_q     <= {DIV_W{1'b0}};
            digit_sel_q   <= 2'd0;
            frame_cnt_q   <= {FRM_W{1'b0}};
            blink_phase_q <= 1'b0;
            digits_snap_q <= 16'd0;
            dp_snap_q     <= 4'd0;
            blink_snap_q  <= 4'd0;
            num_q         <= 4'd0;
            an_q          <= 4'b1111;
            dp_q          <= 1'b1;
            frame_start_q <= 1'b0;
        end else begin
            div_cnt_q     <= div_cnt_d;
            digit_sel_q   <= digit_sel_d;
            frame_cnt_q   <= frame_cnt_d;
            blink_phase_q <= blink_phase_d;
            digits_snap_q <= digits_snap_d;
            dp_snap_q     <= dp_snap_d;
            blink_snap_q  <= blink_snap_d;
            num_q         <= num_d;
            an_q          <= an_d;
            dp_q          <= dp_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign num         = num_q;
    assign an          = an_q;
    assign dp          = dp_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_display_scan_controller.sv
// Self-checking bench for display_scan_controller with REFRESH_DIV=8, DEAD_CYCLES=2, BLINK_FRAMES=2.
// Expected outputs derive from the absolute cycle count since reset release.
module tb_display_scan_controller;

    localparam int RD    = 8;
    localparam int DC    = 2;
    localparam int BF    = 2;
    localparam int FRAME = 4 * RD;
    localparam int MAXF  = 64;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [15:0] digits = 16'd0;
    logic [3:0]  dp_mask = 4'd0;
    logic [3:0]  blink_mask = 4'd0;
    logic [3:0]  num;
    logic [3:0]  an;
    logic        dp;
    logic        frame_start;

    int          total = 0;
    int          bad = 0;
    int          n = 0;
    logic [15:0] sd  [MAXF];
    logic [3:0]  sdm [MAXF];
    logic [3:0]  sbm [MAXF];
    logic [9:0]  exp_v;
    logic [9:0]  got_v;

    display_scan_controller #(
        .REFRESH_DIV (RD),
        .DEAD_CYCLES (DC),
        .BLINK_FRAMES(BF)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .digits     (digits),
        .dp_mask    (dp_mask),
        .blink_mask (blink_mask),
        .num        (num),
        .an         (an),
        .dp         (dp),
        .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    // Expected {an, num, dp, frame_start} after the nn-th rising edge since reset release
    function automatic logic [9:0] model(input int nn);
        int         k, div, sel, f;
        logic [3:0] nib, an_e;
        logic       dp_e, off;
        if (nn == 0) return {4'b1111, 4'd0, 1'b1, 1'b0};
        k   = nn - 1;
        div = k % RD;
        sel = (k / RD) % 4;
        f   = k / FRAME;
        nib = sd[f][sel*4 +: 4];
        off = (div < DC) || ((((f / BF) % 2) == 1) && sbm[f][sel]);
`ifdef LZ_BLANK_EN
        if (sel == 3 && nib == 4'd0) off = 1'b1;
`endif
        an_e = off ? 4'b1111 : ~(4'b0001 << sel);
        dp_e = off ? 1'b1 : ~sdm[f][sel];
        return {an_e, nib, dp_e, ((k % FRAME) == FRAME - 1)};
    endfunction

    task automatic clear_model();
        n = 0;
        for (int i = 0; i < MAXF; i++) begin
            sd[i] = 16'd0; sdm[i] = 4'd0; sbm[i] = 4'd0;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_model();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // One rising edge; record what a frame boundary edge captures
    task automatic tick();
        @(posedge clk);
        n++;
        if ((n % FRAME) == 0 && (n / FRAME) < MAXF) begin
            sd[n / FRAME]  = digits;
            sdm[n / FRAME] = dp_mask;
            sbm[n / FRAME] = blink_mask;
        end
        #1;
    endtask

    task automatic test_reset();
        digits = 16'h5678; dp_mask = 4'b1111; blink_mask = 4'b0000;
        #2 rst_n = 1'b0;
        #1;
        got_v = {an, num, dp, frame_start};
        total++;
        if (got_v !== {4'b1111, 4'd0, 1'b1, 1'b0}) begin
            bad++;
            $display("FAIL reset_async got an|num|dp|fs=%b exp=%b", got_v, {4'b1111, 4'd0, 1'b1, 1'b0});
        end
        repeat (3) @(posedge clk);
        #1;
        got_v = {an, num, dp, frame_start};
        total++;
        if (got_v !== {4'b1111, 4'd0, 1'b1, 1'b0}) begin
            bad++;
            $display("FAIL reset_held got an|num|dp|fs=%b exp=%b", got_v, {4'b1111, 4'd0, 1'b1, 1'b0});
        end
        digits = 16'd0; dp_mask = 4'd0;
    endtask

    task automatic test_startup();
        digits = 16'd0; dp_mask = 4'd0; blink_mask = 4'd0;
        do_reset();
        repeat (40) begin
            tick();
            exp_v = model(n);
            got_v = {an, num, dp, frame_start};
            total++;
            if (got_v !== exp_v) begin
                bad++;
                $display("FAIL startup n=%0d got an|num|dp|fs=%b exp=%b", n, got_v, exp_v);
            end
        end
    endtask

    task automatic test_mid_frame_update();
        digits = 16'd0; dp_mask = 4'd0; blink_mask = 4'd0;
        do_reset();
        repeat (80) begin
            tick();
            exp_v = model(n);
            got_v = {an, num, dp, frame_start};
            total++;
            if (got_v !== exp_v) begin
                bad++;
                $display("FAIL mid_frame n=%0d got an|num|dp|fs=%b exp=%b", n, got_v, exp_v);
            end
            if (n == 10) digits = 16'h1234;
        end
    endtask

    task automatic test_dp();
        digits = 16'h1234; dp_mask = 4'b0100; blink_mask = 4'd0;
        do_reset();
        repeat (80) begin
            tick();
            exp_v = model(n);
            got_v = {an, num, dp, frame_start};
            total++;
            if (got_v !== exp_v) begin
                bad++;
                $display("FAIL dp n=%0d got an|num|dp|fs=%b exp=%b", n, got_v, exp_v);
            end
        end
    endtask

    task automatic test_blink();
        digits = 16'h8765; dp_mask = 4'b1111; blink_mask = 4'b0001;
        do_reset();
        repeat (7 * FRAME) begin
            tick();
            exp_v = model(n);
            got_v = {an, num, dp, frame_start};
            total++;
            if (got_v !== exp_v) begin
                bad++;
                $display("FAIL blink n=%0d got an|num|dp|fs=%b exp=%b", n, got_v, exp_v);
            end
        end
        blink_mask = 4'b1111;
        repeat (6 * FRAME) begin
            tick();
            exp_v = model(n);
            got_v = {an, num, dp, frame_start};
            total++;
            if (got_v !== exp_v) begin
                bad++;
                $display("FAIL blink_all n=%0d got an|num|dp|fs=%b exp=%b", n, got_v, exp_v);
            end
        end
    endtask

    task automatic test_random();
        digits = 16'(($urandom)); dp_mask = 4'($urandom); blink_mask = 4'($urandom);
        do_reset();
        repeat (20 * FRAME) begin
            tick();
            exp_v = model(n);
            got_v = {an, num, dp, frame_start};
            total++;
            if (got_v !== exp_v) begin
                bad++;
                $display("FAIL random n=%0d got an|num|dp|fs=%b exp=%b", n, got_v, exp_v);
            end
            if ($urandom_range(0, 15) == 0) begin
                digits     = 16'($urandom);
                dp_mask    = 4'($urandom);
                blink_mask = 4'($urandom);
            end
        end
    endtask

    task automatic test_reset_mid();
        digits = 16'h1234; dp_mask = 4'b0000; blink_mask = 4'd0;
        do_reset();
        while (n < 52) begin
            tick();
            exp_v = model(n);
            got_v = {an, num, dp, frame_start};
            total++;
            if (got_v !== exp_v) begin
                bad++;
                $display("FAIL pre_reset n=%0d got an|num|dp|fs=%b exp=%b", n, got_v, exp_v);
            end
        end
        #2 rst_n = 1'b0;
        #1;
        got_v = {an, num, dp, frame_start};
        total++;
        if (got_v !== {4'b1111, 4'd0, 1'b1, 1'b0}) begin
            bad++;
            $display("FAIL reset_mid got an|num|dp|fs=%b exp=%b", got_v, {4'b1111, 4'd0, 1'b1, 1'b0});
        end
        clear_model();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (70) begin
            tick();
            exp_v = model(n);
            got_v = {an, num, dp, frame_start};
            total++;
            if (got_v !== exp_v) begin
                bad++;
                $display("FAIL post_reset n=%0d got an|num|dp|fs=%b exp=%b", n, got_v, exp_v);
            end
        end
    endtask

    task automatic test_leading_zero();
        digits = 16'h0930; dp_mask = 4'b1000; blink_mask = 4'd0;
        do_reset();
        repeat (70) begin
            tick();
            exp_v = model(n);
            got_v = {an, num, dp, frame_start};
            total++;
            if (got_v !== exp_v) begin
                bad++;
                $display("FAIL lead_zero n=%0d got an|num|dp|fs=%b exp=%b", n, got_v, exp_v);
            end
        end
    endtask

    initial begin
        test_reset();
        test_startup();
        test_mid_frame_update();
        test_dp();
        test_blink();
        test_random();
        test_reset_mid();
        test_leading_zero();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/display_scan_controller.md
DISPLAY_SCAN_CONTROLLER -- requirements
Module: display_scan_controller

Interface
REQ-001 SHALL have parameter REFRESH_DIV, default 100000: clocks per digit slot; legal range DEAD_CYCLES+2 or more.
REQ-002 SHALL have parameter DEAD_CYCLES, default 4: all-anodes-off clocks at the start of each slot (anti-ghosting).
REQ-003 SHALL have parameter BLINK_FRAMES, default 100: scan frames per blink half-period; legal range 1 or more.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state is on the rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-006 SHALL have port digits, input, 16 bits: four BCD nibbles; [3:0] is digit 0 (rightmost), [15:12] is digit 3.
REQ-007 SHALL have port dp_mask, input, 4 bits: bit i lights the decimal point on digit i.
REQ-008 SHALL have port blink_mask, input, 4 bits: bit i makes digit i blink.
REQ-009 SHALL have port num, output, 4 bits: nibble fed to the shared seven-segment decoder.
REQ-010 SHALL have port an, output, 4 bits: active-low anode enables; bit i drives digit i.
REQ-011 SHALL have port dp, output, 1 bit: active-low decimal point.
REQ-012 SHALL have port frame_start, output, 1 bit: one-clock pulse on each snapshot load.

Function
REQ-013 Counter div_cnt SHALL count 0..REFRESH_DIV-1 and wrap; on wrap, digit_sel (2 bits) SHALL increment modulo 4.
REQ-014 Frame boundary SHALL be div_cnt=REFRESH_DIV-1 with digit_sel=3; there the next edge SHALL load digits, dp_mask and blink_mask into snapshot registers and assert frame_start for exactly one clock.
REQ-015 All of num, an, dp SHALL come from the snapshot only; input changes mid-frame SHALL NOT be visible until the next frame.
REQ-016 Outputs SHALL be registered, one clock of latency from the div_cnt/digit_sel state they reflect.
REQ-017 While div_cnt < DEAD_CYCLES, an SHALL be 4'b1111 and dp SHALL be 1.
REQ-018 Otherwise an SHALL be all ones except bit digit_sel = 0, num SHALL be snapshot nibble digit_sel, and dp SHALL be ~dp_mask_snap[digit_sel].
REQ-019 num SHALL update at the start of each slot, including dead cycles, so the decoder settles before the anode turns on.
REQ-020 Nibbles 10..15 SHALL pass unchanged to num; the decoder blanks them.
REQ-021 Frame counter SHALL count frame boundaries 0..BLINK_FRAMES-1; on wrap, blink_phase SHALL toggle.
REQ-022 When blink_phase=1 and blink_mask_snap[digit_sel]=1, an SHALL stay 4'b1111 and dp SHALL stay 1 for the whole slot.
REQ-023 All digits blinking together SHALL blank completely in phase 1; the counters SHALL keep running.

Reset
REQ-024 rst_n low SHALL immediately force div_cnt=0, digit_sel=0, frame counter=0, blink_phase=0, all snapshots=0, an=4'b1111, num=0, dp=1, frame_start=0.
REQ-025 Reset asserted mid-frame SHALL abort the scan; after release, scanning SHALL restart at digit 0 with a zero snapshot until the first frame boundary.

Configuration
REQ-026 With macro LZ_BLANK_EN defined, digit 3 SHALL be treated as an off slot (an=4'b1111, dp=1) whenever its snapshot nibble is 0; digits 0-2 SHALL be unaffected.
REQ-027 Without LZ_BLANK_EN, a zero digit 3 SHALL display normally as 0.

Verification (REFRESH_DIV=8, DEAD_CYCLES=2, BLINK_FRAMES=2)
REQ-028 Release reset -> an=1111 after edges 1-2, an=1110 with num=0 after edges 3-8, an=1111 after edges 9-10, an=1101 after edge 11.
REQ-029 digits=16'h1234 applied mid-frame -> num stays 0 until after frame_start; next frame shows num 4,3,2,1 on an 1110,1101,1011,0111.
REQ-030 dp_mask=4'b0100 -> dp=0 only while an=1011 and past the dead cycles; dp=1 at all other times.
REQ-031 blink_mask=4'b0001 -> digit 0 lit for 2 frames, dark for 2 frames, repeating; digits 1-3 never dark.
REQ-032 rst_n pulsed low during digit 2 -> an=1111 and num=0 immediately (asynchronous); after release, the REQ-028 sequence repeats.
REQ-033 LZ_BLANK_EN defined, digits=16'h0930 -> digit 3 slot keeps an=1111; digit 0 shows 0 normally; undefined -> an=0111 with num=0.
